// File: rtl/mem_port_arbiter.sv
// Purpose: shares one 16-bit data-memory port between halfword instruction fetch and
//          32-bit execute/memory accesses; each 32-bit access becomes two halfword beats.
// Latency: fetch ack 2 cycles after the IDLE grant cycle, data ack 3 cycles after it.
// Backpressure: requesters hold req/addr/data until their ack; d_busy_o stalls decode
//          while a data request is outstanding; fetch waits at most STARVE_MAX data grants.
// Ports:
//   clk_i, rst_ni                        clock (rising edge), async active-low reset
//   if_req_i/if_addr_i -> if_ack_o/if_rdata_o            fetch requester
//   d_req_i/d_we_i/d_addr_i/d_wdata_i -> d_ack_o/d_rdata_o/d_busy_o   data requester
//   mem_addr_o/mem_re_o/mem_we_o/mem_wdata_o, mem_rdata_i (1-cycle read latency)
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [15:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_ack_o,
  output logic [31:0]       d_rdata_o,
  output logic              d_busy_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [15:0]       mem_wdata_o,
  input  logic [15:0]       mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, F_RD, F_RSP, D_LO, D_HI, D_RSP} state_t;

  localparam logic [ADDR_W-1:0] HW_MASK    = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] HW_STEP    = ADDR_W'(2);
  localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);

  state_t            state;
  logic [3:0]        starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [15:0]       lo_q;
  logic [15:0]       if_rdata_q;
  logic [31:0]       d_rdata_q;
  logic              data_grant;

  // Data wins unless fetch has already waited through STARVE_MAX data grants.
  assign data_grant = d_req_i && !(if_req_i && (starve_cnt == STARVE_LIM));

  assign d_busy_o = d_req_i & ~d_ack_o;

  // Read data arrives from memory during the response cycle itself, so the ack cycle
  // forwards it straight through; the holding registers keep it until the next ack.
  assign if_rdata_o = (state == F_RSP) ? mem_rdata_i : if_rdata_q;
  assign d_rdata_o  = (state == D_RSP && !we_q) ? {mem_rdata_i, lo_q} : d_rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      starve_cnt  <= 4'd0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      lo_q        <= 16'd0;
      if_rdata_q  <= 16'd0;
      d_rdata_q   <= 32'd0;
      if_ack_o    <= 1'b0;
      d_ack_o     <= 1'b0;
      mem_addr_o  <= '0;
      mem_re_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= 16'd0;
    end else begin
      // Strobes and acks are single-cycle; address/wdata hold unless a new beat loads them.
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;
      mem_re_o <= 1'b0;
      mem_we_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (data_grant) begin
            state      <= D_LO;
            addr_q     <= d_addr_i & HW_MASK;
            we_q       <= d_we_i;
            wdata_q    <= d_wdata_i;
            mem_addr_o <= d_addr_i & HW_MASK;
            mem_re_o   <= ~d_we_i;
            mem_we_o   <= d_we_i;
            if (d_we_i) begin
              mem_wdata_o <= d_wdata_i[15:0];
            end
            if (if_req_i) begin
              starve_cnt <= (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
            end else begin
              starve_cnt <= 4'd0;
            end
          end else if (if_req_i) begin
            state      <= F_RD;
            starve_cnt <= 4'd0;
            mem_addr_o <= if_addr_i & HW_MASK;
            mem_re_o   <= 1'b1;
          end
        end
        F_RD: begin
          state    <= F_RSP;
          if_ack_o <= 1'b1;
        end
        F_RSP: begin
          if_rdata_q <= mem_rdata_i;
          state      <= IDLE;
        end
        D_LO: begin
          state      <= D_HI;
          mem_addr_o <= addr_q + HW_STEP;  // wraps modulo 2^ADDR_W
          mem_re_o   <= ~we_q;
          mem_we_o   <= we_q;
          if (we_q) begin
            mem_wdata_o <= wdata_q[31:16];
          end
        end
        D_HI: begin
          if (!we_q) begin
            lo_q <= mem_rdata_i;
          end
          state   <= D_RSP;
          d_ack_o <= 1'b1;
        end
        D_RSP: begin
          if (!we_q) begin
            d_rdata_q <= {mem_rdata_i, lo_q};
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i, d_req_i, d_we_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i;
  logic        if_ack_o, d_ack_o, d_busy_o, mem_re_o, mem_we_o;
  logic [15:0] if_rdata_o, mem_wdata_o;
  logic [15:0] mem_rdata_i = 16'd0;
  logic [31:0] d_rdata_o, mem_addr_o;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .d_busy_o(d_busy_o),
    .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory seen by the DUT, and the reference image the model predicts from.
  logic [15:0] mem     [512];
  logic [15:0] ref_mem [512];

  function automatic logic [8:0] idx(input logic [31:0] a);
    return a[9:1];
  endfunction

  always @(posedge clk_i) begin
    if (mem_we_o) mem[idx(mem_addr_o)] = mem_wdata_o;
    if (mem_re_o) mem_rdata_i <= mem[idx(mem_addr_o)];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [15:0] v);
    mem[idx(a)]     = v;
    ref_mem[idx(a)] = v;
  endtask

  // ---------------- transaction-level reference model + per-cycle compare ----------------
  // One granted transaction at a time; expected bus activity is a function of the
  // offset from its grant cycle. kind: 0 none, 1 fetch, 2 data.
  int          cyc = 0, g = 0, kind = 0, cnt_m = 0, off = 0;
  logic        model_on = 1'b0, idle, we_m;
  logic [31:0] a_m, wd_m, exp_word, l_addr, l_dr;
  logic [15:0] exp_half, l_wd, l_ifr;
  logic        e_re, e_we, e_ia, e_da;

  always @(negedge clk_i) begin
    cyc = cyc + 1;
    if (!rst_ni) begin
      model_on = 1'b1;
      kind = 0; cnt_m = 0;
      l_addr = 32'd0; l_dr = 32'd0; l_wd = 16'd0; l_ifr = 16'd0;
      chk("rst_mem_re", 32'(mem_re_o), 32'd0);
      chk("rst_mem_we", 32'(mem_we_o), 32'd0);
      chk("rst_if_ack", 32'(if_ack_o), 32'd0);
      chk("rst_d_ack", 32'(d_ack_o), 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata_o), 32'd0);
      chk("rst_if_rdata", 32'(if_rdata_o), 32'd0);
      chk("rst_d_rdata", d_rdata_o, 32'd0);
      chk("rst_d_busy", 32'(d_busy_o), 32'(d_req_i));
    end else if (model_on) begin
      off = cyc - g;
      e_re = 1'b0; e_we = 1'b0; e_ia = 1'b0; e_da = 1'b0;
      if (kind == 1) begin
        if (off == 1) begin e_re = 1'b1; l_addr = a_m; end
        if (off == 2) begin e_ia = 1'b1; l_ifr = exp_half; end
      end else if (kind == 2) begin
        if (off == 1 || off == 2) begin
          l_addr = (off == 1) ? a_m : a_m + 32'd2;
          if (we_m) begin
            e_we = 1'b1;
            l_wd = (off == 1) ? wd_m[15:0] : wd_m[31:16];
            ref_mem[idx(l_addr)] = l_wd;
          end else begin
            e_re = 1'b1;
          end
        end
        if (off == 3) begin
          e_da = 1'b1;
          if (!we_m) l_dr = exp_word;
        end
      end
      chk("mem_re", 32'(mem_re_o), 32'(e_re));
      chk("mem_we", 32'(mem_we_o), 32'(e_we));
      chk("if_ack", 32'(if_ack_o), 32'(e_ia));
      chk("d_ack", 32'(d_ack_o), 32'(e_da));
      chk("mem_addr", mem_addr_o, l_addr);
      chk("mem_wdata", 32'(mem_wdata_o), 32'(l_wd));
      chk("if_rdata", 32'(if_rdata_o), 32'(l_ifr));
      chk("d_rdata", d_rdata_o, l_dr);
      chk("d_busy", 32'(d_busy_o), 32'(d_req_i & ~e_da));
      chk("acks_exclusive", 32'(if_ack_o & d_ack_o), 32'd0);

      idle = (kind == 0) || (kind == 1 && off >= 3) || (kind == 2 && off >= 4);
      if (idle) begin
        kind = 0;
        if (d_req_i && !(if_req_i && cnt_m == STARVE_MAX)) begin
          kind = 2; g = cyc;
          a_m = d_addr_i & ~32'd1; we_m = d_we_i; wd_m = d_wdata_i;
          cnt_m = if_req_i ? ((cnt_m < 15) ? cnt_m + 1 : cnt_m) : 0;
          exp_word = {ref_mem[idx(a_m + 32'd2)], ref_mem[idx(a_m)]};
        end else if (if_req_i) begin
          kind = 1; g = cyc;
          a_m = if_addr_i & ~32'd1;
          exp_half = ref_mem[idx(a_m)];
          cnt_m = 0;
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_data(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output int re_cnt, output logic [31:0] hi_addr);
    @(posedge clk_i); #1;
    d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_wdata_i = wd;
    lat = -1; re_cnt = 0; hi_addr = 32'd0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (mem_re_o) re_cnt++;
      if (n == 2) hi_addr = mem_addr_o;
      if (d_ack_o) begin lat = n; break; end
    end
    @(posedge clk_i); #1;
    d_req_i = 1'b0;
  endtask

  task automatic run_fetch(input logic [31:0] addr, output int lat);
    @(posedge clk_i); #1;
    if_req_i = 1'b1; if_addr_i = addr;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (if_ack_o) begin lat = n; break; end
    end
    @(posedge clk_i); #1;
    if_req_i = 1'b0;
  endtask

  task automatic test_read_100();
    int lat, rc;
    logic [31:0] ha;
    preload(32'h100, 16'hBEEF);
    preload(32'h102, 16'hDEAD);
    run_data(1'b0, 32'h100, 32'd0, lat, rc, ha);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_re_count", 32'(rc), 32'd2);
    chk("t1_hi_addr", ha, 32'h102);
    chk("t1_rdata", d_rdata_o, 32'hDEADBEEF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rc, acks, na;
    logic [31:0] ha;
    logic [5:0] ord;
    logic f_pend, d_pend, fa, da;

    for (int i = 0; i < 512; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    rst_ni = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'd0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'd0; d_wdata_i = 32'd0;
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // 1: 32-bit read
    test_read_100();

    // 2: 32-bit write
    run_data(1'b1, 32'h200, 32'h12345678, lat, rc, ha);
    chk("t2_latency", 32'(lat), 32'd3);
    chk("t2_no_re", 32'(rc), 32'd0);
    chk("t2_hi_addr", ha, 32'h202);
    chk("t2_mem_lo", 32'(mem[idx(32'h200)]), 32'h5678);
    chk("t2_mem_hi", 32'(mem[idx(32'h202)]), 32'h1234);

    // 3: fetch with bit0 set
    preload(32'h40, 16'h4770);
    run_fetch(32'h41, lat);
    chk("t3_latency", 32'(lat), 32'd2);
    chk("t3_rdata", 32'(if_rdata_o), 32'h4770);

    // 4: both requesting continuously
    @(posedge clk_i); #1;
    if_req_i = 1'b1; if_addr_i = 32'h80;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h120;
    ord = 6'd0; na = 0;
    for (int n = 0; n < 60 && na < 6; n++) begin
      @(negedge clk_i);
      if (d_ack_o) begin ord = {ord[4:0], 1'b1}; na++; end
      else if (if_ack_o) begin ord = {ord[4:0], 1'b0}; na++; end
    end
    @(posedge clk_i); #1;
    if_req_i = 1'b0; d_req_i = 1'b0;
    chk("t4_grant_order_DDFDDF", 32'(ord), 32'h36);

    // 5: read across the top of the address space
    preload(32'hFFFFFFFE, 16'h5A5A);
    preload(32'h00000000, 16'hC3C3);
    run_data(1'b0, 32'hFFFFFFFE, 32'd0, lat, rc, ha);
    chk("t5_latency", 32'(lat), 32'd3);
    chk("t5_hi_addr_wrap", ha, 32'h00000000);
    chk("t5_rdata", d_rdata_o, 32'hC3C35A5A);

    // 6: reset during the high half of a write
    preload(32'h300, 16'h1111);
    preload(32'h302, 16'h2222);
    @(posedge clk_i); #1;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h300; d_wdata_i = 32'hCAFEF00D;
    @(posedge clk_i); #1;
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    #1;
    chk("t6_we_killed", 32'(mem_we_o), 32'd0);
    chk("t6_re_killed", 32'(mem_re_o), 32'd0);
    d_req_i = 1'b0; d_we_i = 1'b0;
    acks = 0;
    repeat (3) begin @(negedge clk_i); if (d_ack_o) acks++; end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (4) begin @(negedge clk_i); if (d_ack_o) acks++; end
    chk("t6_no_ack", 32'(acks), 32'd0);
    chk("t6_mem_lo_written", 32'(mem[idx(32'h300)]), 32'hF00D);
    chk("t6_mem_hi_untouched", 32'(mem[idx(32'h302)]), 32'h2222);
    test_read_100();

    // Randomised traffic from both requesters, obeying the hold-until-ack rule.
    f_pend = 1'b0; d_pend = 1'b0;
    for (int k = 0; k < 900; k++) begin
      @(negedge clk_i);
      fa = if_ack_o; da = d_ack_o;
      @(posedge clk_i); #1;
      if (fa) begin f_pend = 1'b0; if_req_i = 1'b0; end
      if (da) begin d_pend = 1'b0; d_req_i = 1'b0; end
      if (k < 700) begin
        if (!f_pend && $urandom_range(0, 3) == 0) begin
          f_pend = 1'b1; if_req_i = 1'b1; if_addr_i = $urandom;
        end
        if (!d_pend && $urandom_range(0, 2) == 0) begin
          d_pend = 1'b1; d_req_i = 1'b1;
          d_we_i = 1'($urandom_range(0, 1));
          d_addr_i = $urandom; d_wdata_i = $urandom;
        end
      end else if (!f_pend && !d_pend) begin
        break;
      end
    end
    chk("rand_drained", 32'({f_pend, d_pend}), 32'd0);
    if_req_i = 1'b0; d_req_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
